// File: rtl/mlp_trainer.sv
// mlp_trainer: epoch sequencer for the MLP sample port.
// Streams a stored dataset in training mode, then replays it and scores the returned predictions.
module mlp_trainer #(
   parameter int INPUTS  = 2,
   parameter int OUTPUTS = 1,
   parameter int SAMPLES = 4,
   parameter int EPOCHS  = 100,
   parameter int WIDTH   = 16,
   localparam int AW = (SAMPLES > 1) ? $clog2(SAMPLES) : 1,
   localparam int CW = $clog2(EPOCHS + 1),
   localparam int KW = $clog2(SAMPLES + 1),
   localparam int VW = INPUTS * WIDTH,
   localparam int EW = OUTPUTS * WIDTH
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load_en,
   input  logic [AW-1:0] load_addr,
   input  logic [VW-1:0] load_values,
   input  logic [EW-1:0] load_expected,
   input  logic          start,
   input  logic          stop_on_perfect,
   input  logic [WIDTH-1:0] threshold,
   input  logic [EW-1:0] prediction,
   output logic [VW-1:0] values,
   output logic [EW-1:0] expected,
   output logic          training,
   output logic          busy,
   output logic          done,
   output logic          epoch_done,
   output logic [CW-1:0] epoch_count,
   output logic [KW-1:0] epoch_correct
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_TRAIN = 3'd1;
   localparam logic [2:0] S_EVAL  = 3'd2;
   localparam logic [2:0] S_FIN   = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [VW-1:0] ram_v_q [SAMPLES];
   logic [EW-1:0] ram_e_q [SAMPLES];

   logic [2:0]    state_q, state_d;
   logic [KW-1:0] idx_q, idx_d;
   logic [KW-1:0] run_q, run_d;
   logic [KW-1:0] cor_q, cor_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          stop_q, stop_d;
   logic          done_q, done_d;
   logic          edone_q, edone_d;
   logic          train_q, train_d;
   logic          busy_q, busy_d;
   logic [VW-1:0] values_q, values_d;
   logic [EW-1:0] exp_q, exp_d;
   logic [EW-1:0] prev_e_q, prev_e_d;

   logic          wr_ok;
   logic          hit;
   logic          drive;
   logic [KW-1:0] score;
   logic [KW-1:0] rd_idx;
   logic [AW-1:0] rd;

   assign wr_ok = load_en && (32'(load_addr) < SAMPLES) &&
                  (state_q == S_IDLE || state_q == S_DONE);

   always_comb begin
      hit = 1'b1;
      for (int j = 0; j < OUTPUTS; j++) begin
         if (($signed(prediction[j*WIDTH +: WIDTH]) < $signed(threshold)) !=
             ($signed(prev_e_q[j*WIDTH +: WIDTH]) < $signed(threshold)))
            hit = 1'b0;
      end
   end

   // prediction in cycle e scores the sample shown in cycle e-1
   assign score = run_q +
      KW'(state_q == S_EVAL && idx_q != '0 && hit);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      run_d   = run_q;
      cor_d   = cor_q;
      cnt_d   = cnt_q;
      stop_d  = stop_q;
      done_d  = done_q;
      edone_d = 1'b0;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_TRAIN;
               idx_d   = '0;
               run_d   = '0;
               cor_d   = '0;
               cnt_d   = '0;
               done_d  = 1'b0;
               stop_d  = stop_on_perfect;
            end
         end
         S_TRAIN: begin
            if (idx_q == KW'(SAMPLES - 1)) begin
               state_d = S_EVAL;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         S_EVAL: begin
            run_d = score;
            if (idx_q == KW'(SAMPLES)) begin
               edone_d = 1'b1;
               cnt_d   = cnt_q + 1'b1;
               cor_d   = score;
               run_d   = '0;
               idx_d   = '0;
               if ((32'(cnt_q) + 32'd1 == 32'(EPOCHS)) ||
                   (stop_q && 32'(score) == SAMPLES))
                  state_d = S_FIN;
               else
                  state_d = S_TRAIN;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         S_FIN: begin
            state_d = S_DONE;
            done_d  = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // fetch for the sample shown next cycle; a same-cycle write is forwarded
   always_comb begin
      drive  = (state_d == S_TRAIN) || (state_d == S_EVAL);
      rd_idx = (state_d == S_EVAL && idx_d == KW'(SAMPLES)) ?
               KW'(SAMPLES - 1) : idx_d;
      rd     = AW'(rd_idx);
      values_d = '0;
      exp_d    = '0;
      if (drive) begin
         if (wr_ok && load_addr == rd) begin
            values_d = load_values;
            exp_d    = load_expected;
         end else begin
            values_d = ram_v_q[rd];
            exp_d    = ram_e_q[rd];
         end
      end
      train_d  = (state_d == S_TRAIN);
      busy_d   = drive || (state_d == S_FIN);
      prev_e_d = exp_q;
   end

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         ram_v_q[load_addr] <= load_values;
         ram_e_q[load_addr] <= load_expected;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         run_q    <= '0;
         cor_q    <= '0;
         cnt_q    <= '0;
         stop_q   <= 1'b0;
         done_q   <= 1'b0;
         edone_q  <= 1'b0;
         train_q  <= 1'b0;
         busy_q   <= 1'b0;
         values_q <= '0;
         exp_q    <= '0;
         prev_e_q <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         run_q    <= run_d;
         cor_q    <= cor_d;
         cnt_q    <= cnt_d;
         stop_q   <= stop_d;
         done_q   <= done_d;
         edone_q  <= edone_d;
         train_q  <= train_d;
         busy_q   <= busy_d;
         values_q <= values_d;
         exp_q    <= exp_d;
         prev_e_q <= prev_e_d;
      end
   end

   assign values        = values_q;
   assign expected      = exp_q;
   assign training      = train_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign epoch_done    = edone_q;
   assign epoch_count   = cnt_q;
   assign epoch_correct = cor_q;

endmodule

// File: tb/tb_mlp_trainer.sv
// tb_mlp_trainer: directed runs over the XOR set against a cycle-indexed model
// of the expected output timeline, plus literal checks of key cycles and counts.
module tb_mlp_trainer;

   localparam int S    = 4;
   localparam int NEP  = 2;
   localparam int W    = 16;
   localparam int CW   = $clog2(NEP + 1);
   localparam int KW   = $clog2(S + 1);
   localparam int MAXC = 400;
   localparam logic [15:0] ONE  = 16'h0100;
   localparam logic [15:0] HALF = 16'h0080;

   logic          clk = 1'b0;
   logic          rst;
   logic          load_en;
   logic [1:0]    load_addr;
   logic [31:0]   load_values;
   logic [15:0]   load_expected;
   logic          start;
   logic          stop_on_perfect;
   logic [15:0]   threshold;
   logic [15:0]   prediction;
   logic [31:0]   values;
   logic [15:0]   expected;
   logic          training;
   logic          busy;
   logic          done;
   logic          epoch_done;
   logic [CW-1:0] epoch_count;
   logic [KW-1:0] epoch_correct;

   mlp_trainer #(
      .INPUTS(2), .OUTPUTS(1), .SAMPLES(S), .EPOCHS(NEP), .WIDTH(W)
   ) dut (
      .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
      .load_values(load_values), .load_expected(load_expected),
      .start(start), .stop_on_perfect(stop_on_perfect),
      .threshold(threshold), .prediction(prediction),
      .values(values), .expected(expected), .training(training),
      .busy(busy), .done(done), .epoch_done(epoch_done),
      .epoch_count(epoch_count), .epoch_correct(epoch_correct)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   // stub network: mode 0 echoes expected one cycle late, 1 gives 0, 2 gives HALF
   int mode = 0;
   logic [15:0] stub_q = '0;
   always @(posedge clk) stub_q <= expected;
   assign prediction = (mode == 0) ? stub_q :
                       (mode == 1) ? 16'h0000 : HALF;

   logic [31:0] ds_v [S];
   logic [15:0] ds_e [S];

   logic [31:0] m_v  [MAXC];
   logic [15:0] m_e  [MAXC];
   logic        m_tr [MAXC];
   logic        m_bz [MAXC];
   logic        m_dn [MAXC];
   logic        m_ed [MAXC];
   int          m_ec [MAXC];
   int          m_co [MAXC];

   int errors = 0;
   int checks = 0;
   bit chk_en = 0;
   int run_c0 = 0;
   int done_rel = -1;
   int ed_q [$];

   task automatic chk(string nm, logic [63:0] got, logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, got, want);
      end
   endtask

   task automatic put(int c, logic [31:0] v, logic [15:0] e, logic tr,
                      logic bz, logic dn, logic ed, int ec, int co);
      if (c >= 0 && c < MAXC) begin
         m_v[c] = v; m_e[c] = e; m_tr[c] = tr; m_bz[c] = bz;
         m_dn[c] = dn; m_ed[c] = ed; m_ec[c] = ec; m_co[c] = co;
      end
   endtask

   function automatic int count_correct(int md);
      int n = 0;
      for (int s = 0; s < S; s++) begin
         logic [15:0] p;
         p = (md == 0) ? ds_e[s] : (md == 1) ? 16'h0000 : HALF;
         if (($signed(p) < $signed(HALF)) == ($signed(ds_e[s]) < $signed(HALF)))
            n++;
      end
      return n;
   endfunction

   task automatic plan_zero(int c);
      for (int i = c; i < MAXC; i++) put(i, '0, '0, 0, 0, 0, 0, 0, 0);
   endtask

   // start seen in cycle c0: epoch k shows train/eval from c0+1+k*(2S+1)
   task automatic plan_run(int c0, bit stp, int md);
      int cor, n, base, fin;
      cor = count_correct(md);
      n = (stp && cor == S) ? 1 : NEP;
      for (int k = 0; k < n; k++) begin
         base = c0 + 1 + k * (2 * S + 1);
         for (int i = 0; i < S; i++)
            put(base + i, ds_v[i], ds_e[i], 1, 1, 0, (k > 0 && i == 0), k,
                (k > 0) ? cor : 0);
         for (int e = 0; e <= S; e++)
            put(base + S + e, ds_v[(e < S) ? e : S - 1],
                ds_e[(e < S) ? e : S - 1], 0, 1, 0, 0, k, (k > 0) ? cor : 0);
      end
      fin = c0 + 1 + n * (2 * S + 1);
      put(fin, '0, '0, 0, 1, 0, 1, n, cor);
      for (int c = fin + 1; c < MAXC; c++) put(c, '0, '0, 0, 0, 1, 0, n, cor);
   endtask

   always @(negedge clk) begin
      if (chk_en && cyc < MAXC) begin
         chk("values", 64'(values), 64'(m_v[cyc]));
         chk("expected", 64'(expected), 64'(m_e[cyc]));
         chk("training", 64'(training), 64'(m_tr[cyc]));
         chk("busy", 64'(busy), 64'(m_bz[cyc]));
         chk("done", 64'(done), 64'(m_dn[cyc]));
         chk("epoch_done", 64'(epoch_done), 64'(m_ed[cyc]));
         chk("epoch_count", 64'(epoch_count), 64'(m_ec[cyc]));
         chk("epoch_correct", 64'(epoch_correct), 64'(m_co[cyc]));
      end
      if (cyc > run_c0) begin
         if (epoch_done === 1'b1) ed_q.push_back(cyc - run_c0);
         if (done === 1'b1 && done_rel < 0) done_rel = cyc - run_c0;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic begin_run(bit stp, int md);
      mode = md;
      stop_on_perfect = stp;
      start = 1;
      run_c0 = cyc;
      done_rel = -1;
      ed_q.delete();
      plan_run(cyc, stp, md);
      tick;
      start = 0;
      stop_on_perfect = 0;
      load_en = 0;
   endtask

   task automatic wait_done;
      int n = 0;
      while (done !== 1'b1 && n < 60) begin
         tick;
         n++;
      end
      chk("done_timeout", 64'(n < 60), 64'(1));
      tick;
      tick;
   endtask

   function automatic int ed_at(int i);
      return (ed_q.size() > i) ? ed_q[i] : -1;
   endfunction

   initial begin
      ds_v[0] = {16'h0000, 16'h0000}; ds_e[0] = 16'h0000;
      ds_v[1] = {ONE, 16'h0000};      ds_e[1] = ONE;
      ds_v[2] = {16'h0000, ONE};      ds_e[2] = ONE;
      ds_v[3] = {ONE, ONE};           ds_e[3] = 16'h0000;
      plan_zero(0);
      rst = 0; load_en = 0; load_addr = 0; load_values = 0;
      load_expected = 0; start = 0; stop_on_perfect = 0; threshold = HALF;
      tick;
      tick;
      rst = 1;
      chk_en = 1;
      for (int s = 0; s < S; s++) begin
         load_en = 1; load_addr = 2'(s);
         load_values = ds_v[s]; load_expected = ds_e[s];
         tick;
      end
      load_en = 0;
      repeat (5) tick;
      chk("idle_values", 64'(values), 64'(0));
      chk("idle_training", 64'(training), 64'(0));

      // two perfect epochs
      begin_run(0, 0);
      wait_done;
      chk("A_ed_n", 64'(ed_q.size()), 64'(2));
      chk("A_ed0_cycle", 64'(ed_at(0)), 64'(10));
      chk("A_ed1_cycle", 64'(ed_at(1)), 64'(19));
      chk("A_done_cycle", 64'(done_rel), 64'(20));
      chk("A_correct", 64'(epoch_correct), 64'(4));
      chk("A_count", 64'(epoch_count), 64'(2));

      // constant 0 prediction
      begin_run(0, 1);
      wait_done;
      chk("B_correct", 64'(epoch_correct), 64'(2));

      // early stop after a perfect epoch
      begin_run(1, 0);
      wait_done;
      chk("C_ed_n", 64'(ed_q.size()), 64'(1));
      chk("C_done_cycle", 64'(done_rel), 64'(11));
      chk("C_count", 64'(epoch_count), 64'(1));

      // start and load mid-TRAIN are ignored
      begin_run(0, 0);
      tick;
      start = 1; load_en = 1; load_addr = 2'd1;
      load_values = 32'h0300_0300; load_expected = 16'h0000;
      tick;
      start = 0; load_en = 0;
      wait_done;
      chk("D_ed0_cycle", 64'(ed_at(0)), 64'(10));
      chk("D_correct", 64'(epoch_correct), 64'(4));

      // reset mid-TRAIN
      begin_run(0, 0);
      tick;
      tick;
      rst = 0;
      plan_zero(cyc + 1);
      tick;
      rst = 1;
      chk("E_training", 64'(training), 64'(0));
      chk("E_busy", 64'(busy), 64'(0));
      chk("E_count", 64'(epoch_count), 64'(0));
      repeat (3) tick;

      // prediction sitting exactly on the threshold
      begin_run(0, 2);
      wait_done;
      chk("F_correct", 64'(epoch_correct), 64'(2));

      // load and start together: new entry used at once
      load_en = 1; load_addr = 2'd0;
      load_values = 32'h0500_0300; load_expected = ONE;
      ds_v[0] = 32'h0500_0300; ds_e[0] = ONE;
      begin_run(0, 0);
      chk("G_first_values", 64'(values), 64'(32'h0500_0300));
      wait_done;
      chk("G_correct", 64'(epoch_correct), 64'(4));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mlp_trainer.md
# mlp_trainer

Hardware training sequencer that drives the `MLP` sample interface from the other end: it holds a small labelled dataset, streams it into the network with `training` asserted, then replays it with `training` deasserted and scores the returned predictions. It runs a configured number of epochs and reports per-epoch classification accuracy. It sits between the dataset loader and the `MLP` instance, replacing the simulation-only stimulus loop with synthesizable control.

## Interface

- `inputs`, 2, MLP input count
- `outputs`, 1, MLP output count
- `samples`, 4, dataset depth; minimum 1
- `epochs`, 100, maximum epochs per run; minimum 1

- `clk` in 1 system clock
- `rst` in 1 reset, synchronous and active-low, one clock
- `load_en` in 1 write one dataset entry
- `load_addr` in $clog2(samples) entry index
- `load_values` in sfp[inputs] entry inputs
- `load_expected` in sfp[outputs] entry targets
- `start` in 1 begin a run
- `stop_on_perfect` in 1 end the run early after a perfect epoch; sampled at `start`
- `threshold` in sfp classification threshold, normally `HALF`
- `prediction` in sfp[outputs] from MLP
- `values` out sfp[inputs] to MLP
- `expected` out sfp[outputs] to MLP
- `training` out 1 to MLP
- `busy` out 1 run in progress
- `done` out 1 run finished; level signal
- `epoch_done` out 1 one-cycle pulse at the end of each epoch
- `epoch_count` out $clog2(epochs+1) epochs completed in the current run
- `epoch_correct` out $clog2(samples+1) correct samples in the last completed epoch

## Operation

- Dataset RAM: `samples` entries of {values, expected}. Write on `load_en` only in IDLE or DONE. `load_en` is ignored while `busy`. Contents survive reset; only the controller state is reset.
- States:
  - IDLE: on `start`, go to TRAIN, clear `epoch_count`, `epoch_correct` and `done`, and latch `stop_on_perfect`.
  - TRAIN: one sample per cycle, index 0..S-1, with `training`=1. Go to EVAL after index S-1.
  - EVAL: run S+1 cycles, e0..eS.
    - In e0..e(S-1), drive sample e with `training`=0.
    - In eS, hold the last sample's values with `training`=0.
    - In e1..eS, score the sample driven in the previous cycle against the current `prediction`. Prediction latency is fixed at 1 cycle.
  - End of EVAL: pulse `epoch_done`, increment `epoch_count`, load the running count into `epoch_correct`, and clear the running count.
    - If `epoch_count`+1 == `epochs`, go to DONE.
    - If the latched stop flag is set and the count == S, go to DONE.
    - Otherwise go to TRAIN.
  - DONE: `done`=1. `start` goes to TRAIN as from IDLE.
- `start` while `busy` is ignored. `start` with `load_en` in the same cycle: the write happens and the run starts, and the new entry is used.
- Scoring: a sample is correct when, for every output j, (`prediction[j]` < `threshold`) == (`expected[j]` < `threshold`). Comparisons are signed sfp. Equality with `threshold` counts as "not below".
- In IDLE and DONE, `values`=0, `expected`=0 and `training`=0.
- `busy` = TRAIN or EVAL.

## Timing

- All outputs are registered.
- Reset values: `values`=0, `expected`=0, `training`=0, `busy`=0, `done`=0, `epoch_done`=0, `epoch_count`=0, `epoch_correct`=0. State is IDLE.
- `start` sampled in cycle 0 → first TRAIN sample and `busy`=1 appear in cycle 1.
- One epoch takes 2S+1 cycles. With S=4 that is 9 cycles.
- `epoch_done` and the updated `epoch_count` / `epoch_correct` appear together on the cycle after eS.
- `done` rises one cycle after the final `epoch_done`, and `busy` falls in the same cycle.
- Reset asserted mid-run: on the next edge all outputs return to their reset values, and partial-epoch counts are discarded.

## Test plan

Use a stub MLP in place of the real network. Load the XOR set: {0,0}→0, {0,ONE}→ONE, {ONE,0}→ONE, {ONE,ONE}→0.

- Reset, then idle 5 cycles → every output holds its reset value, with `values`, `expected` and `training` all 0.
- `epochs`=2, stub `prediction` = `expected` registered by 1 cycle, `start` in cycle 0 → `epoch_done` in cycles 10 and 19, `epoch_correct`=4 both times, `epoch_count`=2, `done`=1 in cycle 20.
- Stub `prediction` = 0 constant, 1 epoch → `epoch_correct`=2 (the two samples with expected 0).
- `stop_on_perfect`=1, `epochs`=100, perfect stub → exactly one `epoch_done`, `epoch_count`=1, `done` in cycle 11.
- Mid-TRAIN behaviour:
  - Pulse `start` and `load_en` → no restart and no RAM change, observed as an unchanged `training` sequence.
  - Drop `rst` → next cycle `training`=0, `busy`=0, `epoch_count`=0.
- Stub `prediction` = `threshold` = `HALF` → samples with expected ONE score correct and samples with expected 0 score wrong, giving `epoch_correct`=2.
